// File: rtl/nd_1to2_pkg.sv
// nd_1to2_pkg: shared definitions for the message-network split node.
//   - NS_ON/NS_OFF/NS_TRUE/NS_FALSE level constants
//   - default message sizes (overridable via NS_MESSAGE_FIFO_SIZE, NS_ADDRESS_SIZE,
//     NS_DATA_SIZE macros)
//   - output-port FSM state encoding
//   - message width helper
// Optional feature macro used by the top: ND_1TO2_BCAST_EN.

`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

package nd_1to2_pkg;

    localparam logic NS_ON    = 1'b1;
    localparam logic NS_OFF   = 1'b0;
    localparam logic NS_TRUE  = 1'b1;
    localparam logic NS_FALSE = 1'b0;

    localparam int unsigned NS_FIFO_SIZE_DEF = `NS_MESSAGE_FIFO_SIZE;
    localparam int unsigned NS_ADDR_SIZE_DEF = `NS_ADDRESS_SIZE;
    localparam int unsigned NS_DATA_SIZE_DEF = `NS_DATA_SIZE;

    // Output-port handshake states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDrop = 2'd2
    } out_state_e;

    // Packed message is {src, dst, dat}.
    function automatic int unsigned ns_msg_width(input int unsigned asz,
                                                 input int unsigned dsz);
        return 2 * asz + dsz;
    endfunction

endpackage

// File: rtl/nd_out_port.sv
// nd_out_port: one output channel of the split node.
//   A FIFO of FSZ messages feeding a four-phase sender (IDLE / REQ / DROP).
// Ports:
//   i_clk     clock
//   reset     synchronous active-high reset
//   clr       synchronous clear (init cycle of the parent)
//   push      write push_msg into the FIFO (caller guarantees not full)
//   push_msg  message {src, dst, dat}
//   full      FIFO occupancy == FSZ
//   req       output request
//   ack       output acknowledge
//   msg       output message register, stable from req rise until reload

module nd_out_port
    import nd_1to2_pkg::*;
#(
    parameter int unsigned FSZ = NS_FIFO_SIZE_DEF,
    parameter int unsigned MW  = 24
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic [MW-1:0] push_msg,
    output logic          full,
    output logic          req,
    input  logic          ack,
    output logic [MW-1:0] msg
);

    localparam int unsigned PW = $clog2(FSZ);
    localparam logic [PW:0] FullCnt = (PW + 1)'(FSZ);

    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    logic [MW-1:0] mem_q [FSZ];
    out_state_e    state_q;
    logic          req_q;
    logic [MW-1:0] msg_q;
    logic          pop;

    assign full = (count_q == FullCnt);
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign req  = req_q;
    assign msg  = msg_q;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[tail_q] <= push_msg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset || clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= StIdle;
            req_q   <= NS_OFF;
            msg_q   <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        msg_q   <= mem_q[head_q];
                        req_q   <= NS_ON;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (ack) begin
                        req_q   <= NS_OFF;
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    if (!ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/nd_1to2.sv
// nd_1to2: message-network split node. One four-phase input channel (rcv0) is
// steered to snd0 or snd1 by rcv0_dst[RBIT]; each output has its own FIFO so a
// stalled output does not block the other.
// Ports:
//   i_clk, reset              clock, synchronous active-high reset
//   ready                     high once the post-reset init cycle has run
//   rcv0_req/ack/src/dst/dat  input channel
//   snd0_*, snd1_*            output channels
// Optional feature: define ND_1TO2_BCAST_EN to treat dst all-ones as broadcast
// (pushed to both FIFOs at once, only when neither is full).

module nd_1to2
    import nd_1to2_pkg::*;
#(
    parameter int unsigned FSZ  = NS_FIFO_SIZE_DEF,
    parameter int unsigned ASZ  = NS_ADDR_SIZE_DEF,
    parameter int unsigned DSZ  = NS_DATA_SIZE_DEF,
    parameter int unsigned RBIT = 0
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic           snd1_req,
    input  logic           snd1_ack,
    output logic [ASZ-1:0] snd1_src,
    output logic [ASZ-1:0] snd1_dst,
    output logic [DSZ-1:0] snd1_dat
);

    localparam int unsigned MW = ns_msg_width(ASZ, DSZ);

    logic          ready_q;
    logic          ack_q;
    logic          full0, full1;
    logic          push0, push1;
    logic          want;
    logic [MW-1:0] in_msg, out0, out1;

    assign in_msg = {rcv0_src, rcv0_dst, rcv0_dat};
    assign want   = ready_q && rcv0_req && !ack_q;

    // Fullness is the registered count, so a full FIFO refuses a push even if
    // it pops in the same cycle.
    always_comb begin
        push0 = 1'b0;
        push1 = 1'b0;
        if (want) begin
`ifdef ND_1TO2_BCAST_EN
            if (&rcv0_dst) begin
                // All-or-nothing: never push to just one side.
                push0 = !full0 && !full1;
                push1 = !full0 && !full1;
            end else if (rcv0_dst[RBIT]) begin
                push1 = !full1;
            end else begin
                push0 = !full0;
            end
`else
            if (rcv0_dst[RBIT]) begin
                push1 = !full1;
            end else begin
                push0 = !full0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready_q <= NS_FALSE;
            ack_q   <= NS_OFF;
        end else if (!ready_q) begin
            ready_q <= NS_TRUE;
            ack_q   <= NS_OFF;
        end else if (!ack_q) begin
            if (push0 || push1) begin
                ack_q <= NS_ON;
            end
        end else if (!rcv0_req) begin
            ack_q <= NS_OFF;
        end
    end

    assign ready    = ready_q;
    assign rcv0_ack = ack_q;

    nd_out_port #(
        .FSZ (FSZ),
        .MW  (MW)
    ) u_port0 (
        .i_clk    (i_clk),
        .reset    (reset),
        .clr      (!ready_q),
        .push     (push0),
        .push_msg (in_msg),
        .full     (full0),
        .req      (snd0_req),
        .ack      (snd0_ack),
        .msg      (out0)
    );

    nd_out_port #(
        .FSZ (FSZ),
        .MW  (MW)
    ) u_port1 (
        .i_clk    (i_clk),
        .reset    (reset),
        .clr      (!ready_q),
        .push     (push1),
        .push_msg (in_msg),
        .full     (full1),
        .req      (snd1_req),
        .ack      (snd1_ack),
        .msg      (out1)
    );

    assign {snd0_src, snd0_dst, snd0_dat} = out0;
    assign {snd1_src, snd1_dst, snd1_dat} = out1;

endmodule
